// File: rtl/hd44780_bus_driver.sv
// HD44780 8-bit write-only bus driver: takes one byte + RS per start/done handshake.
// Latency: done pulses T_SETUP+T_EN+T_HOLD+(T_EXEC or T_LONG) cycles after the first SETUP cycle.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module hd44780_bus_driver #(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       rs_in,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counter reload values: a state lasting T cycles loads T-1 and leaves at zero.
  localparam logic [23:0] SETUP_LD = 24'(T_SETUP_CYC - 1);
  localparam logic [23:0] EN_LD    = 24'(T_EN_CYC - 1);
  localparam logic [23:0] HOLD_LD  = 24'(T_HOLD_CYC - 1);
  localparam logic [23:0] EXEC_LD  = 24'(T_EXEC_CYC - 1);
  localparam logic [23:0] LONG_LD  = 24'(T_LONG_CYC - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        long_q, long_d;
  logic        en_q, en_d;
  logic        done_q, done_d;

  // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution wait.
  logic cmd_is_long;
  assign cmd_is_long = !rs_in && ((data_in == 8'h01) || (data_in[7:1] == 7'b0000001));

  // State, counter, captured bus values and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // Next-state sequencing; counter reloads on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          rs_d    = rs_in;
          long_d  = cmd_is_long;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EN_HI;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      EN_HI: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = long_q ? LONG_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // EN and done are decoded from the next state and registered, so the pins never glitch.
  always_comb begin
    en_d   = (state_d == EN_HI);
    done_d = (state_d == DONE);
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_hd44780_bus_driver.sv
// Self-checking bench for hd44780_bus_driver with shortened timing parameters.
// Expected pin values per cycle come from the timing rules (S/E/H/W arithmetic).
// Output vector order: {EN, done, busy, DATA[7:0], RS, RW, ON, BLON}.
module tb_hd44780_bus_driver;

  localparam int S = 2, E = 3, H = 2, X = 5, L = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       rs_in = 1'b0;
  logic       start = 1'b0;
  logic       done, busy, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
  logic [7:0] LCD_DATA;

  int n_cmp = 0;
  int n_err = 0;

  hd44780_bus_driver #(
    .T_SETUP_CYC(S), .T_EN_CYC(E), .T_HOLD_CYC(H), .T_EXEC_CYC(X), .T_LONG_CYC(L)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .rs_in(rs_in), .start(start),
    .done(done), .busy(busy), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {LCD_EN, done, busy, LCD_DATA, LCD_RS, LCD_RW, LCD_ON, LCD_BLON};

  // Reference: cycle at which done fires, counted from first SETUP cycle = 0.
  function automatic int done_cycle(input logic [7:0] d, input logic rs);
    logic [6:0] hi;
    bit lng;
    hi  = d[7:1];
    lng = (rs == 1'b0) && (d == 8'h01 || hi == 7'd1);
    return S + E + H + (lng ? L : X);
  endfunction

  // Reference: full pin vector for cycle c of a transaction (c beyond done = idle, bus held).
  function automatic logic [14:0] model(input int c, input logic [7:0] d, input logic rs);
    int n;
    logic en, dn, bz;
    n  = done_cycle(d, rs);
    en = (c >= S) && (c < S + E);
    dn = (c == n);
    bz = (c <= n);
    return {en, dn, bz, d, rs, 1'b0, 1'b1, 1'b1};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== {3'b000, 8'h00, 4'b0011}) begin
      n_err++; $display("FAIL reset_held obs=%h exp=%h", obs, {3'b000, 8'h00, 4'b0011});
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (obs !== {3'b000, 8'h00, 4'b0011}) begin
      n_err++; $display("FAIL reset_idle obs=%h exp=%h", obs, {3'b000, 8'h00, 4'b0011});
    end
  endtask

  // One transaction, checked every cycle from first SETUP cycle to a few idle cycles after done.
  // With inject set, a competing start (0x55) is pulsed at cycle 5 and must be ignored.
  task automatic check_txn(input logic [7:0] d, input logic rs, input bit inject, input string tag);
    int n;
    logic [14:0] exp;
    n = done_cycle(d, rs);
    @(negedge clk);
    data_in = d; rs_in = rs; start = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= n + 3; c++) begin
      exp = model(c, d, rs);
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL %s cyc=%0d obs=%h exp=%h", tag, c, obs, exp);
      end
      if (c == 0) begin
        start = 1'b0; data_in = 8'($urandom); rs_in = 1'($urandom);
      end
      if (inject && c == 5) begin
        start = 1'b1; data_in = 8'h55; rs_in = 1'b0;
      end
      if (inject && c == 6) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    check_txn(8'h41, 1'b1, 1'b0, "data_41");
  endtask

  task automatic test_exec_wait();
    check_txn(8'h01, 1'b0, 1'b0, "cmd_clear");
    check_txn(8'h03, 1'b0, 1'b0, "cmd_home3");
    check_txn(8'h02, 1'b0, 1'b0, "cmd_home2");
    check_txn(8'h38, 1'b0, 1'b0, "cmd_38");
    check_txn(8'h01, 1'b1, 1'b0, "data_01");
  endtask

  task automatic test_ignore_start();
    check_txn(8'h41, 1'b1, 1'b1, "ignore_55");
  endtask

  // start held high: new transaction every N+2 cycles, data alternating.
  task automatic test_back_to_back();
    localparam int K = 4;
    localparam int P = S + E + H + X + 2;
    logic [7:0] ds [K];
    logic [14:0] exp;
    int k, c;
    for (int i = 0; i < K; i++) ds[i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
    @(negedge clk);
    data_in = ds[0]; rs_in = 1'b1; start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < K * P + 4; t++) begin
      k = t / P; c = t % P;
      if (k >= K) begin
        k = K - 1; c = P + 5;
      end
      exp = model(c, ds[k], 1'b1);
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL b2b t=%0d obs=%h exp=%h", t, obs, exp);
      end
      if (c == 0 && t / P < K - 1) data_in = ds[k + 1];
      if (c == 0 && t / P == K - 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    data_in = 8'h41; rs_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (LCD_EN !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_en_before obs=%b exp=1", LCD_EN);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({LCD_EN, busy, done, LCD_RW, LCD_ON, LCD_BLON} !== 6'b000011) begin
      n_err++;
      $display("FAIL rst_mid_async obs=%b exp=000011", {LCD_EN, busy, done, LCD_RW, LCD_ON, LCD_BLON});
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || LCD_EN || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL rst_mid_quiet obs=%0d active cycles exp=0", seen);
    end
    check_txn(8'h0C, 1'b0, 1'b0, "after_rst_0C");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic rs;
    for (int i = 0; i < 12; i++) begin
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_txn(d, rs, 1'b0, $sformatf("rand%0d_%h_%b", i, d, rs));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_exec_wait();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hd44780_bus_driver.md
# hd44780_bus_driver

Responder side of the `start`/`done` LCD byte handshake: accepts one byte plus register-select from the LCD formatter/initializer FSM and drives it onto the HD44780 16x2 parallel bus (8-bit mode, write-only). It generates setup, enable pulse, hold and command-execution wait timing, then pulses `done`. It sits between the LCD message sequencer and the board LCD pins (DE2-class, 50 MHz).

## Interface
Parameters:
- `T_SETUP_CYC`, default 4: cycles RS/DATA are stable before EN rises (tAS).
- `T_EN_CYC`, default 12: EN high width in cycles (≥230 ns at 50 MHz).
- `T_HOLD_CYC`, default 4: cycles EN is low with RS/DATA held before the execution wait starts.
- `T_EXEC_CYC`, default 2000: execution wait for normal commands and data (40 µs).
- `T_LONG_CYC`, default 100000: execution wait for Clear/Home (2 ms).
- All parameters must be ≥1. The counter is 24 bits wide; values ≥2^24 are illegal.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `data_in` in 8: byte to write.
- `rs_in` in 1: 0 = instruction, 1 = data.
- `start` in 1: request; sampled only in IDLE.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high while a transaction is in progress.
- `LCD_DATA` out 8: LCD data bus.
- `LCD_RS` out 1: LCD register select.
- `LCD_RW` out 1: constant 0 (write only).
- `LCD_EN` out 1: LCD enable strobe.
- `LCD_ON` out 1: constant 1.
- `LCD_BLON` out 1: constant 1.

## Operation
- States: IDLE, SETUP, EN_HI, HOLD, EXEC, DONE. A single down-counter is reloaded on each state entry.
- IDLE, `start`=1 at an edge:
  - capture `data_in`→`LCD_DATA` and `rs_in`→`LCD_RS`;
  - compute the `long` flag: `rs_in`=0 and (`data_in`==8'h01 or `data_in[7:1]`==7'b0000001);
  - go to SETUP.
- SETUP: `LCD_EN`=0 for `T_SETUP_CYC` cycles, then EN_HI.
- EN_HI: `LCD_EN`=1 for `T_EN_CYC` cycles, then HOLD. The HD44780 latches on the falling edge.
- HOLD: `LCD_EN`=0 for `T_HOLD_CYC` cycles, then EXEC.
- EXEC: wait `T_LONG_CYC` cycles if `long`, else `T_EXEC_CYC` cycles, then DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` in any non-IDLE state is ignored (not queued). `data_in`/`rs_in` changes after capture have no effect.
- `start` held high through DONE: a new transaction is accepted on the first IDLE edge (back-to-back, one IDLE cycle between `done` and the next SETUP).
- `LCD_DATA`/`LCD_RS` hold the last captured value in IDLE until the next accepted start.
- `LCD_RW`=0, `LCD_ON`=1, `LCD_BLON`=1 at all times, including during reset.

## Timing
- Reset values: state IDLE, `LCD_DATA`=8'h00, `LCD_RS`=0, `LCD_EN`=0, `done`=0, `busy`=0, counter 0.
- Acceptance edge = E0. The first SETUP cycle follows E0.
- `LCD_EN` is high for cycles `T_SETUP_CYC` .. `T_SETUP_CYC+T_EN_CYC-1`, counted from the first SETUP cycle = 0.
- `done` is high in cycle N = `T_SETUP_CYC+T_EN_CYC+T_HOLD_CYC+W`, where W is the selected exec wait. Defaults: N=2020 for normal, 100020 for long.
- `done` never coincides with the acceptance cycle. Initiators that clear `start` one cycle after raising it and then wait for `done` work unmodified.
- Reset mid-transaction: `LCD_EN` drops to 0 asynchronously; no `done` is emitted; `busy`=0; next start begins a fresh transaction.
- `LCD_EN` must be glitch-free. It is a registered output.

## Test plan
Parameter override for the bench: SETUP=2, EN=3, HOLD=2, EXEC=5, LONG=20.
- Reset release, idle 10 cycles → all outputs at reset values; `LCD_ON`=`LCD_BLON`=1, `LCD_RW`=0.
- `start` 1 cycle, `data_in`=8'h41, `rs_in`=1 → `LCD_DATA`=8'h41 and `LCD_RS`=1 from cycle 0; EN high in cycles 2–4; `done` a single pulse at cycle 12; `busy` high in cycles 0–12.
- Command 8'h01 (rs=0) → `done` at cycle 27. Command 8'h03 → `done` at cycle 27. Command 8'h38 → `done` at cycle 12. Data byte 8'h01 (rs=1) → `done` at cycle 12.
- Pulse `start` with 8'h55 at cycle 5 of a running 8'h41 transfer → ignored: `LCD_DATA` stays 8'h41; exactly one `done`; only one EN pulse.
- Hold `start` high continuously with alternating data → consecutive transactions, each 14 cycles (13 busy + 1 IDLE); one EN pulse and one `done` each.
- Assert `reset` during EN_HI (cycle 3) → `LCD_EN`=0 immediately; no `done`; a following 8'h0C command completes normally at cycle 12.
